// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, control-bit indices and step constants for the SAP-style CPU
package cpu_pkg;

  localparam int CW_W   = 15;
  localparam int STEP_W = 3;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int CP   = 14;
  localparam int EP   = 13;
  localparam int LP   = 12;
  localparam int NLMA = 11;
  localparam int NLMD = 10;
  localparam int NCE  = 9;
  localparam int NLR  = 8;
  localparam int NLI  = 7;
  localparam int NEI  = 6;
  localparam int NLA  = 5;
  localparam int EA   = 4;
  localparam int SUB  = 3;
  localparam int EU   = 2;
  localparam int NLB  = 1;
  localparam int NLO  = 0;

  // Active-low bits parked high, active-high bits low.
  localparam logic [CW_W-1:0] CW_IDLE = 15'h0FE3;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;
  localparam logic [STEP_W-1:0] T5 = 3'd5;

endpackage

// File: rtl/microcode_sequencer_if.sv
// rtl/microcode_sequencer_if.sv - opcode/flag inputs and control-word outputs of the sequencer
interface microcode_sequencer_if;
  import cpu_pkg::*;

  logic [3:0]        opcode;
  logic              cf;
  logic              zf;
  logic [CW_W-1:0]   control_word;
  logic [STEP_W-1:0] step;
  logic              halted;

  modport master (input opcode, cf, zf, output control_word, step, halted);
  modport slave  (output opcode, cf, zf, input control_word, step, halted);

endinterface

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational decode of (step, opcode, flags) into control word and last-step flag
module microcode_rom
  import cpu_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  input  logic [3:0]        opcode,
  input  logic              cf,
  input  logic              zf,
  output logic [CW_W-1:0]   cw,
  output logic              last_step
);

  always_comb begin
    cw        = CW_IDLE;
    last_step = 1'b0;
    case (step)
      T0: begin
        cw[EP]   = 1'b1;
        cw[NLMA] = 1'b0;
      end
      T1: cw[CP] = 1'b1;
      T2: begin
        cw[NCE] = 1'b0;
        cw[NLI] = 1'b0;
      end
      T3: begin
        last_step = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[NEI]   = 1'b0;
            cw[NLMA]  = 1'b0;
            last_step = 1'b0;
          end
          OP_LDI: begin
            cw[NEI] = 1'b0;
            cw[NLA] = 1'b0;
          end
          OP_JMP: begin
            cw[NEI] = 1'b0;
            cw[LP]  = 1'b1;
          end
          OP_JC: if (cf) begin
            cw[NEI] = 1'b0;
            cw[LP]  = 1'b1;
          end
          OP_JZ: if (zf) begin
            cw[NEI] = 1'b0;
            cw[LP]  = 1'b1;
          end
          OP_OUT: begin
            cw[EA]  = 1'b1;
            cw[NLO] = 1'b0;
          end
          default: ;
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            cw[NCE]   = 1'b0;
            cw[NLA]   = 1'b0;
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[NCE] = 1'b0;
            cw[NLB] = 1'b0;
            cw[SUB] = (opcode == OP_SUB);
          end
          OP_STA: begin
            cw[EA]   = 1'b1;
            cw[NLMD] = 1'b0;
          end
          // Opcode changed under a short instruction: end it rather than run on.
          default: last_step = 1'b1;
        endcase
      end
      T5: begin
        last_step = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB: begin
            cw[EU]  = 1'b1;
            cw[NLA] = 1'b0;
            cw[SUB] = (opcode == OP_SUB);
          end
          OP_STA: cw[NLR] = 1'b0;
          default: ;
        endcase
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - T-step counter and HALT state driving the CPU control word
module microcode_sequencer
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  clear,
  microcode_sequencer_if.master bus
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  logic [CW_W-1:0]   rom_cw;
  logic              rom_last;

  microcode_rom u_rom (
    .step      (step_q),
    .opcode    (bus.opcode),
    .cf        (bus.cf),
    .zf        (bus.zf),
    .cw        (rom_cw),
    .last_step (rom_last)
  );

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = step_q;
    end else if (step_q == T3 && bus.opcode == OP_HLT) begin
      halted_d = 1'b1;
    end else if (rom_last) begin
      step_d = T0;
    end else begin
      step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign bus.control_word = (clear || halted_q) ? CW_IDLE : rom_cw;
  assign bus.step         = step_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed bench for the microcode sequencer
module tb_microcode_sequencer;
  import cpu_pkg::*;

  localparam logic [14:0] W_IDLE = 15'h0FE3;
  localparam logic [14:0] F0     = 15'h27E3;
  localparam logic [14:0] F1     = 15'h4FE3;
  localparam logic [14:0] F2     = 15'h0D63;
  localparam logic [14:0] W_MAR  = 15'h07A3;
  localparam logic [14:0] W_JMP  = 15'h1FA3;

  logic clk;
  logic clear;
  int   n_cmp;
  int   n_bad;
  bit   run_bus_chk;

  microcode_sequencer_if io ();

  microcode_sequencer dut (
    .clk   (clk),
    .clear (clear),
    .bus   (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input int len,
                           input logic [5:0][14:0] exp, input bit wiggle);
    io.opcode = op;
    for (int s = 0; s < len; s++) begin
      if (wiggle && s >= 4) begin
        io.cf = ~io.cf;
        io.zf = ~io.zf;
      end
      #1;
      check_eq($sformatf("op%0d_T%0d_step", op, s), 32'(io.step), 32'(s));
      check_eq($sformatf("op%0d_T%0d_word", op, s), 32'(io.control_word), 32'(exp[s]));
      tick();
    end
    check_eq($sformatf("op%0d_wrap_step", op), 32'(io.step), 32'd0);
  endtask

  always @(negedge clk) begin
    if (run_bus_chk && !clear) begin
      int drv;
      drv = int'(io.control_word[EP]) + int'(!io.control_word[NEI]) +
            int'(!io.control_word[NCE]) + int'(io.control_word[EA]) +
            int'(io.control_word[EU]);
      check_eq("bus_excl", 32'(drv <= 1), 32'd1);
      check_eq("step_range", 32'(io.step <= 3'd5), 32'd1);
    end
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    run_bus_chk = 1'b0;
    clear       = 1'b1;
    io.opcode   = OP_NOP;
    io.cf       = 1'b0;
    io.zf       = 1'b0;

    tick();
    tick();
    check_eq("rst_word", 32'(io.control_word), 32'(W_IDLE));
    check_eq("rst_step", 32'(io.step), 32'd0);
    check_eq("rst_halted", 32'(io.halted), 32'd0);
    clear = 1'b0;
    #1;
    check_eq("rel_T0_word", 32'(io.control_word), 32'(F0));
    run_bus_chk = 1'b1;

    run_instr(OP_LDA, 5, {15'h0, 15'h0DC3, W_MAR, F2, F1, F0}, 1'b0);
    run_instr(OP_ADD, 6, {15'h0FC7, 15'h0DE1, W_MAR, F2, F1, F0}, 1'b1);
    run_instr(OP_SUB, 6, {15'h0FCF, 15'h0DE9, W_MAR, F2, F1, F0}, 1'b0);
    run_instr(OP_STA, 6, {15'h0EE3, 15'h0BF3, W_MAR, F2, F1, F0}, 1'b0);
    run_instr(OP_LDI, 4, {15'h0, 15'h0, 15'h0F83, F2, F1, F0}, 1'b0);
    run_instr(OP_JMP, 4, {15'h0, 15'h0, W_JMP, F2, F1, F0}, 1'b0);
    io.cf = 1'b0; io.zf = 1'b1;
    run_instr(OP_JC, 4, {15'h0, 15'h0, W_IDLE, F2, F1, F0}, 1'b0);
    io.cf = 1'b1; io.zf = 1'b0;
    run_instr(OP_JC, 4, {15'h0, 15'h0, W_JMP, F2, F1, F0}, 1'b0);
    run_instr(OP_JZ, 4, {15'h0, 15'h0, W_IDLE, F2, F1, F0}, 1'b0);
    io.zf = 1'b1;
    run_instr(OP_JZ, 4, {15'h0, 15'h0, W_JMP, F2, F1, F0}, 1'b0);
    run_instr(OP_OUT, 4, {15'h0, 15'h0, 15'h0FF2, F2, F1, F0}, 1'b0);
    run_instr(OP_NOP, 4, {15'h0, 15'h0, W_IDLE, F2, F1, F0}, 1'b0);
    run_instr(4'd11, 4, {15'h0, 15'h0, W_IDLE, F2, F1, F0}, 1'b0);

    io.opcode = OP_HLT;
    tick(); tick(); tick();
    check_eq("hlt_T3_step", 32'(io.step), 32'd3);
    check_eq("hlt_T3_word", 32'(io.control_word), 32'(W_IDLE));
    check_eq("hlt_T3_halted", 32'(io.halted), 32'd0);
    tick();
    io.opcode = OP_LDA;
    for (int i = 0; i < 20; i++) begin
      check_eq("hlt_step", 32'(io.step), 32'd3);
      check_eq("hlt_word", 32'(io.control_word), 32'(W_IDLE));
      check_eq("hlt_halted", 32'(io.halted), 32'd1);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    check_eq("hlt_clr_step", 32'(io.step), 32'd0);
    check_eq("hlt_clr_halted", 32'(io.halted), 32'd0);
    check_eq("hlt_clr_word", 32'(io.control_word), 32'(F0));

    io.opcode = OP_ADD;
    tick(); tick(); tick(); tick();
    check_eq("mid_T4_step", 32'(io.step), 32'd4);
    clear = 1'b1;
    #1;
    check_eq("mid_clr_word", 32'(io.control_word), 32'(W_IDLE));
    tick();
    clear = 1'b0;
    #1;
    check_eq("mid_step", 32'(io.step), 32'd0);
    check_eq("mid_halted", 32'(io.halted), 32'd0);
    check_eq("mid_word", 32'(io.control_word), 32'(F0));

    for (int i = 0; i < 300; i++) begin
      io.opcode = 4'($urandom_range(0, 14));
      io.cf     = 1'($urandom_range(0, 1));
      io.zf     = 1'($urandom_range(0, 1));
      tick();
    end
    check_eq("rand_not_halted", 32'(io.halted), 32'd0);

    run_bus_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
